// File: rtl/card_draw_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : card_draw_sequencer_if
//  Description : Signal bundle between the card draw sequencer, the
//                player/dealer game FSMs and the shared counter datapath.
//                master = sequencer side, slave = surrounding logic.
//  Ports       : i_Tick2K, i_ReqPlayer, i_ReqDealer, i_Count, i_TwoSec
//                (into the sequencer); o_CntSeed, o_CntClear, o_CntAct,
//                o_GntPlayer, o_GntDealer, o_Card, o_Busy, o_Fault (out of it).
//  Revision    : 1.0  initial release
// ============================================================================
interface card_draw_sequencer_if #(
    parameter int WIDTH = 12
);
    logic             i_Tick2K;
    logic             i_ReqPlayer;
    logic             i_ReqDealer;
    logic [WIDTH-1:0] i_Count;
    logic             i_TwoSec;
    logic             o_CntSeed;
    logic             o_CntClear;
    logic             o_CntAct;
    logic             o_GntPlayer;
    logic             o_GntDealer;
    logic [3:0]       o_Card;
    logic             o_Busy;
    logic             o_Fault;

    modport master (
        input  i_Tick2K, i_ReqPlayer, i_ReqDealer, i_Count, i_TwoSec,
        output o_CntSeed, o_CntClear, o_CntAct, o_GntPlayer, o_GntDealer,
               o_Card, o_Busy, o_Fault
    );

    modport slave (
        output i_Tick2K, i_ReqPlayer, i_ReqDealer, i_Count, i_TwoSec,
        input  o_CntSeed, o_CntClear, o_CntAct, o_GntPlayer, o_GntDealer,
               o_Card, o_Busy, o_Fault
    );
endinterface
`default_nettype wire

// File: rtl/card_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : card_draw_sequencer
//  Description : Owns the shared game counter. Free-runs it as an entropy
//                source while idle; on a player/dealer draw request samples
//                it as a card (1..13), clears it, runs it as a 2 s display
//                timer and then grants the card to the round-robin winner.
//                A tick-based watchdog ends a stuck timer and flags o_Fault.
//  Ports       : clk_50M      - 50 MHz system clock
//                i_RstCounter - asynchronous active-high reset
//                bus          - card_draw_sequencer_if.master bundle
//  Revision    : 1.0  initial release
// ============================================================================
module card_draw_sequencer #(
    parameter int WIDTH   = 12,
    parameter int TIMEOUT = 4200
) (
    input  wire logic             clk_50M,
    input  wire logic             i_RstCounter,
    card_draw_sequencer_if.master bus
);

    localparam int C_WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_CLEAR   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    // Last-served requester doubles as the owner of the draw in flight.
    logic              r_last_dealer;
    logic [3:0]        r_card;
    logic [C_WD_W-1:0] r_wdog;
    logic              r_fault;

    logic              w_any_req;
    logic              w_pick_dealer;
    logic [C_WD_W-1:0] w_wdog_inc;
    logic              w_wd_expire;
    logic [3:0]        w_card;

    assign w_any_req = bus.i_ReqPlayer | bus.i_ReqDealer;
    // Dealer wins when alone, or on a tie when the player was served last.
    assign w_pick_dealer = bus.i_ReqDealer & (~bus.i_ReqPlayer | ~r_last_dealer);

    // Remainder is < 13, so truncating to 4 bits is lossless.
    assign w_card = 4'(bus.i_Count % WIDTH'(13)) + 4'd1;

    assign w_wdog_inc = r_wdog + C_WD_W'(1);
    // i_TwoSec wins over a coincident final tick, so no fault in that case.
    assign w_wd_expire = (r_state == S_HOLD) && !bus.i_TwoSec && bus.i_Tick2K
                         && (w_wdog_inc == C_WD_W'(TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_CLEAR;
            S_CLEAR:   w_state_nxt = S_HOLD;
            S_HOLD:    if (bus.i_TwoSec || w_wd_expire) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge i_RstCounter) begin
        if (i_RstCounter) begin
            r_state       <= S_IDLE;
            r_last_dealer <= 1'b1;
            r_card        <= 4'd0;
            r_wdog        <= '0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any_req) begin
                r_last_dealer <= w_pick_dealer;
            end
            if (r_state == S_CAPTURE) begin
                r_card <= w_card;
            end
            if (r_state == S_CLEAR) begin
                r_wdog <= '0;
            end else if (r_state == S_HOLD && bus.i_Tick2K && !bus.i_TwoSec) begin
                r_wdog <= w_wdog_inc;
            end
            if (w_wd_expire) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Counter mode controls are pure state decodes, hence mutually exclusive.
    assign bus.o_CntSeed   = (r_state == S_IDLE);
    assign bus.o_CntClear  = (r_state == S_CLEAR) || (r_state == S_DONE);
    assign bus.o_CntAct    = (r_state == S_HOLD);
    assign bus.o_GntPlayer = (r_state == S_DONE) && !r_last_dealer;
    assign bus.o_GntDealer = (r_state == S_DONE) &&  r_last_dealer;
    assign bus.o_Card      = r_card;
    assign bus.o_Busy      = (r_state != S_IDLE);
    assign bus.o_Fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_card_draw_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_card_draw_sequencer
//  Description : Scoreboard bench for card_draw_sequencer. Expected grants
//                {owner, card} are queued when requests are driven and
//                compared when a grant pulse appears. A small counter model
//                produces i_TwoSec and i_Tick2K.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_card_draw_sequencer;

    localparam int C_TIMEOUT = 4200;

    logic clk_50M      = 1'b0;
    logic i_RstCounter = 1'b1;

    card_draw_sequencer_if #(.WIDTH(12)) bus ();

    card_draw_sequencer #(.WIDTH(12), .TIMEOUT(C_TIMEOUT)) dut (
        .clk_50M      (clk_50M),
        .i_RstCounter (i_RstCounter),
        .bus          (bus)
    );

    always #10 clk_50M = ~clk_50M;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- counter model ----------------
    int   hold_cnt      = 0;
    int   hold_len      = 10;
    int   ticks_in_hold = 0;
    logic twosec_en     = 1'b1;
    logic stale_twosec  = 1'b0;
    logic tick_en       = 1'b0;
    logic tick_phase    = 1'b0;

    always @(posedge clk_50M) begin
        hold_cnt   <= bus.o_CntAct ? hold_cnt + 1 : 0;
        tick_phase <= ~tick_phase;
        if (bus.o_CntClear) ticks_in_hold <= 0;
        else if (bus.o_CntAct && bus.i_Tick2K) ticks_in_hold <= ticks_in_hold + 1;
    end

    assign bus.i_TwoSec = stale_twosec || (twosec_en && bus.o_CntAct && hold_cnt >= hold_len);
    assign bus.i_Tick2K = tick_en & tick_phase;

    // ---------------- scoreboard ----------------
    logic [4:0] exp_q[$];   // {dealer, card}
    logic       tb_last_dealer = 1'b1;

    always @(negedge clk_50M) begin
        logic [4:0] e;
        if (bus.o_CntSeed + bus.o_CntClear + bus.o_CntAct > 2'd1)
            check("cnt_mode_exclusive", 0, 1);
        if (bus.o_GntPlayer || bus.o_GntDealer) begin
            if (bus.o_GntPlayer && bus.o_GntDealer) check("gnt_both", 1, 0);
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_owner_dealer", 32'(bus.o_GntDealer), 32'(e[4]));
                check("gnt_card", 32'(bus.o_Card), 32'(e[3:0]));
            end
        end
    end

    task automatic push_exp(input logic dealer, input logic [3:0] card);
        exp_q.push_back({dealer, card});
        tb_last_dealer = dealer;
    endtask

    task automatic wait_grant(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_50M);
            if (bus.o_GntPlayer || bus.o_GntDealer) seen = 1;
        end
        if (!seen) check("grant_timeout", 0, 1);
    endtask

    task automatic draw_one(input logic dealer, input logic [11:0] cnt, input logic [3:0] card);
        bus.i_Count = cnt;
        push_exp(dealer, card);
        if (dealer) bus.i_ReqDealer = 1'b1;
        else        bus.i_ReqPlayer = 1'b1;
        wait_grant(200);
        bus.i_ReqPlayer = 1'b0;
        bus.i_ReqDealer = 1'b0;
        repeat (2) @(negedge clk_50M);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic tie_round(input logic [11:0] cnt, input logic [3:0] card);
        bus.i_Count = cnt;
        if (tb_last_dealer) begin push_exp(1'b0, card); push_exp(1'b1, card); end
        else                begin push_exp(1'b1, card); push_exp(1'b0, card); end
        bus.i_ReqPlayer = 1'b1;
        bus.i_ReqDealer = 1'b1;
        wait_grant(200);
        bus.i_ReqPlayer = 1'b0;     // first winner expected to be the player
        wait_grant(200);
        bus.i_ReqDealer = 1'b0;
        repeat (2) @(negedge clk_50M);
        check("tie_drained", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_seed"}, 32'(bus.o_CntSeed), 1);
        check({tag, "_clear"}, 32'(bus.o_CntClear), 0);
        check({tag, "_act"}, 32'(bus.o_CntAct), 0);
        check({tag, "_busy"}, 32'(bus.o_Busy), 0);
        check({tag, "_fault"}, 32'(bus.o_Fault), 0);
        check({tag, "_card"}, 32'(bus.o_Card), 0);
        check({tag, "_gnt"}, 32'({bus.o_GntPlayer, bus.o_GntDealer}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int act_cycles;
        bit seen;
        bus.i_ReqPlayer = 1'b0;
        bus.i_ReqDealer = 1'b0;
        bus.i_Count     = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk_50M);
        check_idle_outputs("rst");
        i_RstCounter = 1'b0;
        @(negedge clk_50M);
        check_idle_outputs("post_rst");

        // ---- single player draw with latency checks ----
        bus.i_Count = 12'd25;
        push_exp(1'b0, 4'd13);
        bus.i_ReqPlayer = 1'b1;
        @(negedge clk_50M);
        check("lat_capture_busy", 32'(bus.o_Busy), 1);
        check("lat_capture_clear", 32'(bus.o_CntClear), 0);
        @(negedge clk_50M);
        check("lat_clear", 32'(bus.o_CntClear), 1);
        check("lat_card_n2", 32'(bus.o_Card), 13);
        @(negedge clk_50M);
        check("lat_act", 32'(bus.o_CntAct), 1);
        check("lat_act_clear", 32'(bus.o_CntClear), 0);
        wait_grant(200);
        bus.i_ReqPlayer = 1'b0;
        repeat (2) @(negedge clk_50M);
        check("single_drained", exp_q.size(), 0);

        // ---- tie arbitration from a fresh reset, twice ----
        i_RstCounter = 1'b1;
        tb_last_dealer = 1'b1;
        @(negedge clk_50M);
        i_RstCounter = 1'b0;
        hold_len = 3;
        tie_round(12'd3, 4'd4);
        tie_round(12'd100, 4'd10);

        // ---- card mapping, single requesters ----
        draw_one(1'b0, 12'd0,    4'd1);
        draw_one(1'b1, 12'd12,   4'd13);
        draw_one(1'b1, 12'd4095, 4'd1);
        draw_one(1'b0, 12'd13,   4'd1);

        // ---- watchdog ----
        check("fault_pre", 32'(bus.o_Fault), 0);
        twosec_en = 1'b0;
        tick_en   = 1'b1;
        bus.i_Count = 12'd40;
        push_exp(1'b1, 4'd2);
        bus.i_ReqDealer = 1'b1;
        wait_grant(10000);
        bus.i_ReqDealer = 1'b0;
        check("wd_fault", 32'(bus.o_Fault), 1);
        check("wd_ticks", 32'(ticks_in_hold), C_TIMEOUT);
        repeat (2) @(negedge clk_50M);
        twosec_en = 1'b1;
        draw_one(1'b0, 12'd7, 4'd8);
        check("fault_sticky", 32'(bus.o_Fault), 1);
        tick_en = 1'b0;

        // ---- reset mid-HOLD ----
        bus.i_Count = 12'd5;
        push_exp(1'b0, 4'd6);
        hold_len = 30;
        bus.i_ReqPlayer = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_50M);
            if (bus.o_CntAct) seen = 1;
        end
        check("mid_hold_reached", 32'(seen), 1);
        repeat (3) @(negedge clk_50M);
        #3 i_RstCounter = 1'b1;
        #1 check_idle_outputs("mid_rst");
        exp_q.delete();
        tb_last_dealer = 1'b1;
        bus.i_ReqPlayer = 1'b0;
        @(negedge clk_50M);
        i_RstCounter = 1'b0;
        repeat (40) @(negedge clk_50M);
        hold_len = 3;
        tie_round(12'd1, 4'd2);

        // ---- stale TwoSec, request dropped during CLEAR ----
        stale_twosec = 1'b1;
        repeat (2) @(negedge clk_50M);
        bus.i_Count = 12'd20;
        push_exp(1'b0, 4'd8);
        bus.i_ReqPlayer = 1'b1;
        act_cycles = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_50M);
            if (bus.o_CntClear && !bus.o_GntPlayer) bus.i_ReqPlayer = 1'b0;
            if (bus.o_CntAct) act_cycles++;
            if (bus.o_GntPlayer || bus.o_GntDealer) seen = 1;
        end
        check("stale_grant_seen", 32'(seen), 1);
        check("stale_hold_ge1", 32'(act_cycles >= 1), 1);
        stale_twosec = 1'b0;
        bus.i_ReqPlayer = 1'b0;
        repeat (10) @(negedge clk_50M);
        check("final_drained", exp_q.size(), 0);
        check("final_idle", 32'(bus.o_Busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/card_draw_sequencer.md
# card_draw_sequencer

Controller that owns the shared game counter and sequences it for card draws. While idle it lets the counter free-run at 50 MHz as an entropy source. On a draw request from the player or the dealer it samples the counter as a card value, clears the counter, and runs it as a 2-second display timer. When the timer expires it delivers the card to the granted requester. Sits between the player/dealer game FSMs and the counter datapath.

## Interface

**Parameters**
- WIDTH, 12: width of the counter value bus.
- TIMEOUT, 4200: watchdog limit in i_Tick2K pulses while waiting for i_TwoSec.

**Ports**
- clk_50M  input  1  system clock, 50 MHz.
- i_RstCounter  input  1  reset; asynchronous, active-high; clock clk_50M.
- i_Tick2K  input  1  single-cycle 2 kHz tick, already synchronous to clk_50M.
- i_ReqPlayer  input  1  player draw request; level, sampled only in IDLE.
- i_ReqDealer  input  1  dealer draw request; level, sampled only in IDLE.
- i_Count  input  WIDTH  current counter value.
- i_TwoSec  input  1  counter 2-second-elapsed flag.
- o_CntSeed  output  1  counter free-run (entropy) enable.
- o_CntClear  output  1  one-cycle counter clear pulse.
- o_CntAct  output  1  counter timer-mode enable.
- o_GntPlayer  output  1  one-cycle pulse: card delivered to player.
- o_GntDealer  output  1  one-cycle pulse: card delivered to dealer.
- o_Card  output  4  drawn card value, 1..13; holds its value between draws.
- o_Busy  output  1  high in every state except IDLE.
- o_Fault  output  1  sticky watchdog flag; cleared only by reset.

## Operation

**States:** IDLE, CAPTURE, CLEAR, HOLD, DONE.

- **IDLE**
  - o_CntSeed=1.
  - If any request is high, latch the winner into the owner register and go to CAPTURE.
- **CAPTURE**
  - o_Card <= (i_Count mod 13) + 1, using i_Count sampled in this cycle.
  - Next state: CLEAR.
- **CLEAR**
  - o_CntClear=1 for exactly one cycle.
  - Zero the watchdog counter.
  - Next state: HOLD.
- **HOLD**
  - o_CntAct=1.
  - Each i_Tick2K pulse increments the watchdog.
  - If i_TwoSec=1, go to DONE.
  - Else if watchdog reaches TIMEOUT, set o_Fault and go to DONE.
- **DONE**
  - Pulse the grant for the latched owner.
  - o_CntClear=1.
  - Next state: IDLE.

**Arbitration**
- Round-robin with a last-served register.
- On simultaneous requests, the requester not served last wins.
- After reset, last-served = dealer, so the player wins the first tie.
- A single requester always wins.

**Request handling**
- A request dropped after the grant decision does not abort the draw; the sequence completes and the grant still pulses.
- A requester must drop its request within 1 cycle after its grant, or it is re-served.

**Other rules**
- mod 13 is computed on the full WIDTH-bit value.
- o_CntSeed, o_CntClear and o_CntAct are mutually exclusive; each is decoded from registered state.

## Timing

**Reset values**
- State = IDLE, so o_CntSeed=1.
- o_CntClear, o_CntAct, o_GntPlayer, o_GntDealer, o_Busy, o_Fault = 0.
- o_Card = 0; last-served = dealer; watchdog = 0.

**Latency** (request first sampled high in IDLE at edge N)
- CAPTURE during cycle N+1.
- o_CntClear high during N+2.
- o_CntAct high from N+3.
- Grant pulses in the cycle after i_TwoSec is sampled high.

**Output timing**
- o_Card is stable from N+2 until the next CAPTURE.
- o_Card is valid when the grant pulses.

**i_TwoSec handling**
- i_TwoSec is ignored outside HOLD.
- A stale-high i_TwoSec cannot end HOLD early, because CLEAR precedes HOLD.

**i_Tick2K handling**
- Ticks are ignored outside HOLD.
- A tick in the same cycle as i_TwoSec: i_TwoSec takes precedence, and o_Fault is not set.

**Reset mid-sequence**
- Asserting reset in any state returns to IDLE within the same cycle (asynchronous).
- No grant is issued; o_Card returns to 0; o_Fault clears.

**Back-to-back draws**
- Minimum spacing between grants is 5 cycles plus the timer duration.

## Test plan

- **Single player draw:** reset, hold i_Count=25, pulse i_ReqPlayer, model i_TwoSec high 10 cycles into HOLD.
  - o_Card=13.
  - o_CntClear high at N+2.
  - o_GntPlayer pulses once; o_GntDealer stays 0.
- **Tie arbitration:** both requests high from reset, each dropped after its own grant.
  - Grant order: player then dealer.
  - Repeat with both high again: player then dealer.
- **Card mapping:** i_Count=0 → 1; i_Count=12 → 13; i_Count=4095 → 1 (4095 mod 13 = 0); i_Count=13 → 1.
- **Watchdog:** hold i_TwoSec=0, give 4200 i_Tick2K pulses in HOLD.
  - o_Fault=1; grant pulses on the following cycle.
  - o_Fault stays 1 through the next normal draw.
- **Reset mid-HOLD:** assert i_RstCounter during HOLD.
  - State returns to IDLE with o_CntSeed=1 and o_Busy=0.
  - No grant is issued; o_Card=0.
- **Stale TwoSec and request drop:** i_TwoSec held high before the request.
  - HOLD still lasts at least one cycle.
  - A request dropped in CLEAR still yields a grant pulse.
